gate_sequencer: RTL

- Controller that sequences the frequency-measurement datapath: opens fixed-length gate windows, counts leading-edge pulses, converts the count to tens/units by repeated subtraction, and hands results to the display driver with a valid/ready handshake.
- The gate length is programmable at run time from the `period`/`period_load` inputs. A shadow register applies each new period only at a window boundary.
- Sits between the edge detector and the seven-segment driver.

---
 rtl/gate_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/gate_sequencer.sv
// Gate window sequencer: count edges over a programmable window, convert to BCD, hand off.
// Define FREQ_OVERFLOW_EN to flag windows with more than 99 edges and force 9/9.
module gate_sequencer #(
    parameter int BITS           = 12,
    parameter int PERIOD_DEFAULT = 1200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            edge_pulse,
    input  logic [BITS-1:0] period,
    input  logic            period_load,
    input  logic            result_ready,
    output logic [3:0]      ten_count,
    output logic [3:0]      unit_count,
    output logic            result_valid,
    output logic            window_active,
    output logic [BITS-1:0] period_active,
    output logic            overflow
);

    typedef enum logic [1:0] {
        S_COUNT   = 2'd0,
        S_CONVERT = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    localparam logic [BITS-1:0] PDEF     = BITS'(PERIOD_DEFAULT);
    localparam logic [BITS-1:0] ONE      = BITS'(1);
    localparam logic [6:0]      EDGE_MAX = 7'd99;

    state_t          state;
    state_t          state_nxt;
    logic [BITS-1:0] cycle_cnt;
    logic [BITS-1:0] pending;
    logic [BITS-1:0] active;
    logic [6:0]      edge_cnt;
    logic [3:0]      tens_acc;
    logic [3:0]      ten_nxt;
    logic [3:0]      unit_nxt;
    logic            window_end;
    logic            conv_done;
    logic            accept;

    assign window_end = (cycle_cnt == (active - ONE));
    assign conv_done  = (edge_cnt < 7'd10);
    assign accept     = (state == S_PRESENT) && result_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_COUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_COUNT;
        case (state)
            S_COUNT:   state_nxt = window_end ? S_CONVERT : S_COUNT;
            S_CONVERT: state_nxt = conv_done ? S_PRESENT : S_CONVERT;
            S_PRESENT: state_nxt = accept ? S_COUNT : S_PRESENT;
            default:   state_nxt = S_COUNT;
        endcase
    end

    always_comb begin
        window_active = (state == S_COUNT);
        result_valid  = (state == S_PRESENT);
    end

`ifdef FREQ_OVERFLOW_EN
    logic ovf_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_bit  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == S_COUNT && edge_pulse && edge_cnt == EDGE_MAX)
                ovf_bit <= 1'b1;
            else if (accept)
                ovf_bit <= 1'b0;
            if (state == S_CONVERT && conv_done)
                overflow <= ovf_bit;
        end
    end

    assign ten_nxt  = ovf_bit ? 4'd9 : tens_acc;
    assign unit_nxt = ovf_bit ? 4'd9 : edge_cnt[3:0];
`else
    assign overflow = 1'b0;
    assign ten_nxt  = tens_acc;
    assign unit_nxt = edge_cnt[3:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= '0;
            edge_cnt   <= '0;
            tens_acc   <= '0;
            ten_count  <= '0;
            unit_count <= '0;
        end else begin
            case (state)
                S_COUNT: begin
                    if (edge_pulse && edge_cnt != EDGE_MAX)
                        edge_cnt <= edge_cnt + 7'd1;
                    cycle_cnt <= window_end ? '0 : cycle_cnt + ONE;
                end
                S_CONVERT: begin
                    if (!conv_done) begin
                        edge_cnt <= edge_cnt - 7'd10;
                        tens_acc <= tens_acc + 4'd1;
                    end else begin
                        ten_count  <= ten_nxt;
                        unit_count <= unit_nxt;
                        edge_cnt   <= '0;
                        tens_acc   <= '0;
                    end
                end
                S_PRESENT: ;
                default: begin
                    cycle_cnt <= '0;
                    edge_cnt  <= '0;
                    tens_acc  <= '0;
                end
            endcase
        end
    end

    // Shadow period: new lengths take effect only when the next window opens
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= PDEF;
            active  <= PDEF;
        end else begin
            if (period_load && period != '0)
                pending <= period;
            if (accept)
                active <= pending;
        end
    end

    assign period_active = active;

endmodule
